// File: rtl/serial_pe_pkg.sv
// Shared types and constants for the serial_pe MAC unit and its sequencer.
package serial_pe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Bit positions inside the PE ctl field.
    localparam int CTL_FIRST = 0;
    localparam int CTL_LAST  = 1;

    localparam int OP_W  = 16;
    localparam int RES_W = 2 * OP_W;

endpackage

// File: rtl/serial_pe_agen.sv
// Element/output counters and neuron/weight read-address generation.
module serial_pe_agen #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              adv_i,
    input  logic [LEN_W-1:0]  vec_len_i,
    input  logic [LEN_W-1:0]  num_out_i,
    input  logic [ADDR_W-1:0] n_base_i,
    input  logic [ADDR_W-1:0] w_base_i,
    output logic [ADDR_W-1:0] n_addr_o,
    output logic [ADDR_W-1:0] w_addr_o,
    output logic              k_first_o,
    output logic              k_last_o,
    output logic              job_last_o
);

    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  num_q, num_d;
    logic [LEN_W-1:0]  k_q, k_d;
    logic [LEN_W-1:0]  o_q, o_d;
    logic [ADDR_W-1:0] n_base_q, n_base_d;
    logic [ADDR_W-1:0] n_addr_q, n_addr_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;

    assign n_addr_o   = n_addr_q;
    assign w_addr_o   = w_addr_q;
    assign k_first_o  = (k_q == {LEN_W{1'b0}});
    assign k_last_o   = (k_q == (len_q - LEN_W'(1)));
    assign job_last_o = k_last_o && (o_q == (num_q - LEN_W'(1)));

    // Next-state: weight address is a free-running counter since w = base + o*len + k.
    always_comb begin
        len_d    = len_q;
        num_d    = num_q;
        k_d      = k_q;
        o_d      = o_q;
        n_base_d = n_base_q;
        n_addr_d = n_addr_q;
        w_addr_d = w_addr_q;
        if (load_i) begin
            len_d    = vec_len_i;
            num_d    = num_out_i;
            n_base_d = n_base_i;
            k_d      = {LEN_W{1'b0}};
            o_d      = {LEN_W{1'b0}};
            n_addr_d = n_base_i;
            w_addr_d = w_base_i;
        end else if (adv_i) begin
            w_addr_d = w_addr_q + ADDR_W'(1);
            if (k_last_o) begin
                k_d      = {LEN_W{1'b0}};
                o_d      = o_q + LEN_W'(1);
                n_addr_d = n_base_q;
            end else begin
                k_d      = k_q + LEN_W'(1);
                n_addr_d = n_addr_q + ADDR_W'(1);
            end
        end else begin
            k_d = k_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= {LEN_W{1'b0}};
            num_q    <= {LEN_W{1'b0}};
            k_q      <= {LEN_W{1'b0}};
            o_q      <= {LEN_W{1'b0}};
            n_base_q <= {ADDR_W{1'b0}};
            n_addr_q <= {ADDR_W{1'b0}};
            w_addr_q <= {ADDR_W{1'b0}};
        end else begin
            len_q    <= len_d;
            num_q    <= num_d;
            k_q      <= k_d;
            o_q      <= o_d;
            n_base_q <= n_base_d;
            n_addr_q <= n_addr_d;
            w_addr_q <= w_addr_d;
        end
    end

endmodule

// File: rtl/serial_pe_ctrl.sv
// Sequencer for one serial_pe: issues buffer reads, aligns PE valid/ctl with
// the returning data and writes each finished result to the result buffer.
module serial_pe_ctrl
    import serial_pe_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  vec_len,
    input  logic [LEN_W-1:0]  num_out,
    input  logic [ADDR_W-1:0] n_base,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] r_base,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              n_rd,
    output logic [ADDR_W-1:0] n_addr,
    output logic              w_rd,
    output logic [ADDR_W-1:0] w_addr,
    output logic              pe_vld_i,
    output logic [1:0]        pe_ctl,
    input  logic [RES_W-1:0]  pe_result,
    input  logic              pe_vld_o,
    output logic              r_wr,
    output logic [ADDR_W-1:0] r_addr,
    output logic [RES_W-1:0]  r_data
);

    localparam int CNT_W = LEN_W + 1;

    state_e            state_q;
    logic              busy_q;
    logic              done_q;
    logic [LEN_W-1:0]  num_q;
    logic [ADDR_W-1:0] r_base_q;
    logic [CNT_W-1:0]  res_cnt_q;
    logic              vld_sh_q;
    logic              first_sh_q;
    logic              last_sh_q;

    logic              load_s;
    logic              rd_s;
    logic              empty_job_s;
    logic              last_wr_s;
    logic              k_first_s;
    logic              k_last_s;
    logic              job_last_s;

    assign load_s      = (state_q == ST_IDLE) && start;
    assign rd_s        = (state_q == ST_RUN) && !stall;
    assign empty_job_s = (vec_len == {LEN_W{1'b0}}) || (num_out == {LEN_W{1'b0}});
    assign last_wr_s   = pe_vld_o && ((res_cnt_q + CNT_W'(1)) == {1'b0, num_q});

    serial_pe_agen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_agen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load_s),
        .adv_i      (rd_s),
        .vec_len_i  (vec_len),
        .num_out_i  (num_out),
        .n_base_i   (n_base),
        .w_base_i   (w_base),
        .n_addr_o   (n_addr),
        .w_addr_o   (w_addr),
        .k_first_o  (k_first_s),
        .k_last_o   (k_last_s),
        .job_last_o (job_last_s)
    );

    assign n_rd             = rd_s;
    assign w_rd             = rd_s;
    assign pe_vld_i         = vld_sh_q;
    assign pe_ctl[CTL_FIRST] = first_sh_q;
    assign pe_ctl[CTL_LAST]  = last_sh_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign r_wr             = pe_vld_o;
    assign r_data           = pe_result;
    assign r_addr           = r_base_q + ADDR_W'(res_cnt_q);

    // Job FSM with registered busy/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            num_q    <= {LEN_W{1'b0}};
            r_base_q <= {ADDR_W{1'b0}};
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        num_q    <= num_out;
                        r_base_q <= r_base;
                        busy_q   <= 1'b1;
                        if (empty_job_s) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (rd_s && job_last_s) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (last_wr_s) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // One-cycle shadow of the read so valid/ctl line up with buffer data; result counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sh_q   <= 1'b0;
            first_sh_q <= 1'b0;
            last_sh_q  <= 1'b0;
            res_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            vld_sh_q   <= rd_s;
            first_sh_q <= rd_s && k_first_s;
            last_sh_q  <= rd_s && k_last_s;
            if (load_s) begin
                res_cnt_q <= {CNT_W{1'b0}};
            end else if (pe_vld_o) begin
                res_cnt_q <= res_cnt_q + CNT_W'(1);
            end else begin
                res_cnt_q <= res_cnt_q;
            end
        end
    end

endmodule

// File: tb/tb_serial_pe_ctrl.sv
// Directed bench for serial_pe_ctrl with a small behavioural PE that counts
// elements per dot product, so each result encodes the ctl sequence it saw.
module tb_serial_pe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  vec_len = 8'd0;
    logic [7:0]  num_out = 8'd0;
    logic [9:0]  n_base = 10'd0;
    logic [9:0]  w_base = 10'd0;
    logic [9:0]  r_base = 10'd0;
    logic        stall = 1'b0;
    logic        busy, done, n_rd, w_rd, pe_vld_i, r_wr;
    logic [9:0]  n_addr, w_addr, r_addr;
    logic [1:0]  pe_ctl;
    logic [31:0] pe_result, r_data;
    logic        pe_vld_o;

    int n_checks = 0;
    int n_fails = 0;

    logic [7:0]  s_ctrl [0:63];
    logic [9:0]  s_na   [0:63];
    logic [9:0]  s_wa   [0:63];
    logic [9:0]  s_ra   [0:63];
    logic [31:0] s_rd   [0:63];

    serial_pe_ctrl #(.ADDR_W(10), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len), .num_out(num_out),
        .n_base(n_base), .w_base(w_base), .r_base(r_base), .stall(stall),
        .busy(busy), .done(done), .n_rd(n_rd), .n_addr(n_addr), .w_rd(w_rd), .w_addr(w_addr),
        .pe_vld_i(pe_vld_i), .pe_ctl(pe_ctl), .pe_result(pe_result), .pe_vld_o(pe_vld_o),
        .r_wr(r_wr), .r_addr(r_addr), .r_data(r_data)
    );

    always #5 clk = ~clk;

    // Behavioural PE: result = 0xABC00000 | element count since the last "first".
    logic [15:0] acc_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= 16'd0;
            pe_vld_o  <= 1'b0;
            pe_result <= 32'd0;
        end else begin
            pe_vld_o <= pe_vld_i & pe_ctl[1];
            if (pe_vld_i) begin
                acc_q     <= pe_ctl[0] ? 16'd1 : acc_q + 16'd1;
                pe_result <= 32'hABC0_0000 | (pe_ctl[0] ? 32'd1 : {16'd0, acc_q + 16'd1});
            end
        end
    end

    function automatic logic [7:0] cv(input logic rd, input logic vld, input logic [1:0] ctl,
                                      input logic wr, input logic dn, input logic bz);
        return {rd, rd, vld, ctl, wr, dn, bz};
    endfunction

    function automatic logic [1:0] ctl_of(input int e, input int len);
        logic [1:0] r;
        r = 2'b00;
        if (e % len == 0) r[0] = 1'b1;
        if (e % len == len - 1) r[1] = 1'b1;
        return r;
    endfunction

    // Start in cycle 0, then scramble the job inputs and record cycles 1..ncyc.
    task automatic run_job(input int len, input int nout, input logic [9:0] nb, input logic [9:0] wb,
                           input logic [9:0] rb, input logic [63:0] smask, input int rs_c, input int ncyc);
        @(posedge clk); #1;
        vec_len = len[7:0]; num_out = nout[7:0];
        n_base = nb; w_base = wb; r_base = rb;
        start = 1'b1; stall = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            vec_len = 8'd3; num_out = 8'd5;
            n_base = 10'h155; w_base = 10'h2AA; r_base = 10'h0F0;
            start = (c == rs_c);
            stall = smask[c];
            @(negedge clk);
            s_ctrl[c] = {n_rd, w_rd, pe_vld_i, pe_ctl, r_wr, done, busy};
            s_na[c] = n_addr; s_wa[c] = w_addr; s_ra[c] = r_addr; s_rd[c] = r_data;
        end
        start = 1'b0; stall = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        n_checks++;
        if ({busy, done, n_rd, w_rd, pe_vld_i, pe_ctl, r_wr, n_addr, w_addr, r_addr} !== 38'd0) begin
            n_fails++;
            $display("FAIL reset_outputs got=%b exp=0", {busy, done, n_rd, w_rd, pe_vld_i, pe_ctl, r_wr, n_addr, w_addr, r_addr});
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_basic;
        run_job(4, 2, 10'h000, 10'h100, 10'h200, 64'd0, 0, 14);
        for (int c = 1; c <= 14; c++) begin
            logic rd, vld, wr;
            logic [1:0] ctl;
            logic [7:0] exp;
            rd  = (c <= 8);
            vld = (c >= 2) && (c <= 9);
            wr  = (c == 6) || (c == 10);
            ctl = vld ? ctl_of(c - 2, 4) : 2'b00;
            exp = cv(rd, vld, ctl, wr, c == 11, c <= 11);
            n_checks++;
            if (s_ctrl[c] !== exp) begin
                n_fails++;
                $display("FAIL basic_ctrl cyc=%0d got=%b exp=%b", c, s_ctrl[c], exp);
            end
            if (rd) begin
                n_checks++;
                if ({s_na[c], s_wa[c]} !== {10'((c - 1) % 4), 10'h100 + 10'(c - 1)}) begin
                    n_fails++;
                    $display("FAIL basic_addr cyc=%0d got n=%h w=%h", c, s_na[c], s_wa[c]);
                end
            end
            if (wr) begin
                n_checks++;
                if ({s_ra[c], s_rd[c]} !== {(c == 10) ? 10'h201 : 10'h200, 32'hABC0_0004}) begin
                    n_fails++;
                    $display("FAIL basic_wr cyc=%0d got addr=%h data=%h", c, s_ra[c], s_rd[c]);
                end
            end
        end
    endtask

    task automatic test_len_one;
        run_job(1, 3, 10'h010, 10'h020, 10'h030, 64'd0, 0, 9);
        for (int c = 1; c <= 9; c++) begin
            logic rd, vld, wr;
            logic [7:0] exp;
            rd  = (c <= 3);
            vld = (c >= 2) && (c <= 4);
            wr  = (c >= 3) && (c <= 5);
            exp = cv(rd, vld, vld ? 2'b11 : 2'b00, wr, c == 6, c <= 6);
            n_checks++;
            if (s_ctrl[c] !== exp) begin
                n_fails++;
                $display("FAIL len1_ctrl cyc=%0d got=%b exp=%b", c, s_ctrl[c], exp);
            end
            if (rd) begin
                n_checks++;
                if ({s_na[c], s_wa[c]} !== {10'h010, 10'h020 + 10'(c - 1)}) begin
                    n_fails++;
                    $display("FAIL len1_addr cyc=%0d got n=%h w=%h", c, s_na[c], s_wa[c]);
                end
            end
            if (wr) begin
                n_checks++;
                if ({s_ra[c], s_rd[c]} !== {10'h030 + 10'(c - 3), 32'hABC0_0001}) begin
                    n_fails++;
                    $display("FAIL len1_wr cyc=%0d got addr=%h data=%h", c, s_ra[c], s_rd[c]);
                end
            end
        end
    endtask

    task automatic test_stall;
        run_job(4, 2, 10'h000, 10'h100, 10'h200, 64'h18, 0, 16);
        for (int c = 1; c <= 16; c++) begin
            logic rd, vld, wr;
            logic [1:0] ctl;
            logic [7:0] exp;
            int j;
            rd  = (c <= 2) || ((c >= 5) && (c <= 10));
            vld = ((c >= 2) && (c <= 3)) || ((c >= 6) && (c <= 11));
            wr  = (c == 8) || (c == 12);
            ctl = vld ? ctl_of((c <= 3) ? c - 2 : c - 4, 4) : 2'b00;
            exp = cv(rd, vld, ctl, wr, c == 13, c <= 13);
            n_checks++;
            if (s_ctrl[c] !== exp) begin
                n_fails++;
                $display("FAIL stall_ctrl cyc=%0d got=%b exp=%b", c, s_ctrl[c], exp);
            end
            j = (c <= 2) ? c - 1 : c - 3;
            if (rd) begin
                n_checks++;
                if ({s_na[c], s_wa[c]} !== {10'(j % 4), 10'h100 + 10'(j)}) begin
                    n_fails++;
                    $display("FAIL stall_addr cyc=%0d got n=%h w=%h", c, s_na[c], s_wa[c]);
                end
            end
            if (wr) begin
                n_checks++;
                if ({s_ra[c], s_rd[c]} !== {(c == 12) ? 10'h201 : 10'h200, 32'hABC0_0004}) begin
                    n_fails++;
                    $display("FAIL stall_wr cyc=%0d got addr=%h data=%h", c, s_ra[c], s_rd[c]);
                end
            end
        end
    endtask

    task automatic test_zero_len;
        for (int t = 0; t < 2; t++) begin
            if (t == 0) run_job(0, 5, 10'h001, 10'h002, 10'h003, 64'd0, 0, 6);
            else        run_job(3, 0, 10'h001, 10'h002, 10'h003, 64'd0, 0, 6);
            for (int c = 1; c <= 6; c++) begin
                logic [7:0] exp;
                exp = cv(1'b0, 1'b0, 2'b00, 1'b0, c == 1, c == 1);
                n_checks++;
                if (s_ctrl[c] !== exp) begin
                    n_fails++;
                    $display("FAIL zero_ctrl t=%0d cyc=%0d got=%b exp=%b", t, c, s_ctrl[c], exp);
                end
            end
        end
    endtask

    task automatic test_wrap_restart;
        logic [9:0] wtab [0:3];
        wtab[0] = 10'h3FE; wtab[1] = 10'h3FF; wtab[2] = 10'h000; wtab[3] = 10'h001;
        run_job(4, 1, 10'h000, 10'h3FE, 10'h3FF, 64'd0, 2, 12);
        for (int c = 1; c <= 12; c++) begin
            logic rd, vld;
            logic [1:0] ctl;
            logic [7:0] exp;
            rd  = (c <= 4);
            vld = (c >= 2) && (c <= 5);
            ctl = vld ? ctl_of(c - 2, 4) : 2'b00;
            exp = cv(rd, vld, ctl, c == 6, c == 7, c <= 7);
            n_checks++;
            if (s_ctrl[c] !== exp) begin
                n_fails++;
                $display("FAIL wrap_ctrl cyc=%0d got=%b exp=%b", c, s_ctrl[c], exp);
            end
            if (rd) begin
                n_checks++;
                if (s_wa[c] !== wtab[c - 1]) begin
                    n_fails++;
                    $display("FAIL wrap_waddr cyc=%0d got=%h exp=%h", c, s_wa[c], wtab[c - 1]);
                end
            end
            if (c == 6) begin
                n_checks++;
                if ({s_ra[c], s_rd[c]} !== {10'h3FF, 32'hABC0_0004}) begin
                    n_fails++;
                    $display("FAIL wrap_wr cyc=%0d got addr=%h data=%h", c, s_ra[c], s_rd[c]);
                end
            end
        end
    endtask

    task automatic test_mid_reset;
        @(posedge clk); #1;
        vec_len = 8'd8; num_out = 8'd8; n_base = 10'h111; w_base = 10'h222; r_base = 10'h333;
        start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        n_checks++;
        if ({busy, n_rd} !== 2'b11) begin
            n_fails++;
            $display("FAIL midrst_pre got busy,n_rd=%b exp=11", {busy, n_rd});
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, n_rd, w_rd, pe_vld_i, pe_ctl, r_wr, n_addr, w_addr, r_addr} !== 38'd0) begin
            n_fails++;
            $display("FAIL midrst_outputs got=%b exp=0", {busy, done, n_rd, w_rd, pe_vld_i, pe_ctl, r_wr, n_addr, w_addr, r_addr});
        end
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        run_job(2, 1, 10'h020, 10'h040, 10'h060, 64'd0, 0, 7);
        for (int c = 1; c <= 7; c++) begin
            logic rd, vld;
            logic [7:0] exp;
            rd  = (c <= 2);
            vld = (c >= 2) && (c <= 3);
            exp = cv(rd, vld, vld ? ctl_of(c - 2, 2) : 2'b00, c == 4, c == 5, c <= 5);
            n_checks++;
            if (s_ctrl[c] !== exp) begin
                n_fails++;
                $display("FAIL midrst_ctrl cyc=%0d got=%b exp=%b", c, s_ctrl[c], exp);
            end
            if (rd) begin
                n_checks++;
                if ({s_na[c], s_wa[c]} !== {10'h020 + 10'(c - 1), 10'h040 + 10'(c - 1)}) begin
                    n_fails++;
                    $display("FAIL midrst_addr cyc=%0d got n=%h w=%h", c, s_na[c], s_wa[c]);
                end
            end
            if (c == 4) begin
                n_checks++;
                if ({s_ra[c], s_rd[c]} !== {10'h060, 32'hABC0_0002}) begin
                    n_fails++;
                    $display("FAIL midrst_wr cyc=%0d got addr=%h data=%h", c, s_ra[c], s_rd[c]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_one();
        test_stall();
        test_zero_len();
        test_wrap_restart();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/serial_pe_ctrl.md
# serial_pe_ctrl

Sequencer for one `serial_pe` MAC unit. It computes `num_out` dot products of length `vec_len` from a neuron buffer and a weight buffer. It issues buffer reads and drives the PE's `vld_i`/`ctl` aligned with the returning data. It writes each finished PE result to a result buffer. It sits between the layer-level scheduler (start/done handshake) and the PE plus its three single-port buffers.

## Interface
Parameters:
- `ADDR_W`, 10: address width of all three buffers.
- `LEN_W`, 8: width of `vec_len` and `num_out`.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: job request; sampled only in IDLE.
- `vec_len` in LEN_W: MACs per output, captured at start.
- `num_out` in LEN_W: number of outputs, captured at start.
- `n_base` in ADDR_W: neuron buffer base address.
- `w_base` in ADDR_W: weight buffer base address.
- `r_base` in ADDR_W: result buffer base address.
- `stall` in 1: suppresses new read issue while high.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle pulse at job end.
- `n_rd` out 1: neuron buffer read enable.
- `n_addr` out ADDR_W: neuron buffer read address.
- `w_rd` out 1: weight buffer read enable.
- `w_addr` out ADDR_W: weight buffer read address.
- `pe_vld_i` out 1: to PE `vld_i`.
- `pe_ctl` out 2: to PE `ctl`; bit0 = first element (load), bit1 = last element (emit).
- `pe_result` in 32: from PE `result`.
- `pe_vld_o` in 1: from PE `vld_o`.
- `r_wr` out 1: result buffer write enable.
- `r_addr` out ADDR_W: result buffer write address.
- `r_data` out 32: result buffer write data.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: `start`=1 captures all job inputs.
    - If `vec_len`=0 or `num_out`=0, go to DONE; no reads and no PE activity.
    - Otherwise go to RUN.
  - RUN, each cycle with `stall`=0: issue one read (`n_rd`=`w_rd`=1) at element index k of output o.
    - `n_addr` = `n_base`+k; the neuron vector is reused for every output.
    - `w_addr` = `w_base`+o*`vec_len`+k, kept as a running counter with no multiplier.
    - k wraps to 0 after `vec_len`-1, then o increments.
    - After the read for (o=`num_out`-1, k=`vec_len`-1), go to DRAIN.
  - RUN with `stall`=1: no read; counters hold; nothing enters the PE in the next cycle.
  - DRAIN: wait until `num_out` results have been written, then go to DONE.
  - DONE: one cycle, then IDLE.
- Buffer read latency is exactly 1 cycle. A 1-stage shadow of (read issued, k==0, k==`vec_len`-1) drives `pe_vld_i`, `pe_ctl[0]` and `pe_ctl[1]` in the cycle after the read.
- `vec_len`=1 gives `pe_ctl`=2'b11.
- `pe_ctl`=0 whenever `pe_vld_i`=0.
- Result writeback is combinational from the PE:
  - `r_wr` = `pe_vld_o`;
  - `r_data` = `pe_result`;
  - `r_addr` = `r_base` + result counter. The counter increments on each `r_wr`.
- All address arithmetic is modulo 2^ADDR_W; silent wrap.
- `start` while not IDLE is ignored. Inputs may change freely after capture.
- `busy`=1 in RUN, DRAIN and DONE.

## Timing
- Reset values: `busy`, `done`, `n_rd`, `w_rd`, `pe_vld_i`, `r_wr` = 0; `pe_ctl`=0; all address outputs 0; FSM = IDLE; all counters 0.
- `start` sampled in cycle 0. With no stall, for L=`vec_len` and N=`num_out`:
  - reads issue in cycles 1..L·N;
  - `pe_vld_i` is high in cycles 2..L·N+1;
  - `pe_vld_o`/`r_wr` for output o falls in cycle (o+1)·L+2;
  - `done` falls in cycle L·N+3;
  - `busy` is high in cycles 1..L·N+3.
- Each stall cycle delays all subsequent events by one cycle.
- Stall has no effect on a read already issued: its data still reaches the PE next cycle.
- Zero-length job: `busy` and `done` both high in cycle 1 only.
- Reset mid-job: immediate return to IDLE with reset values. The result buffer may hold a partial job; the PE resets on the same `rst_n`.

## Structure
- Shared package `serial_pe_pkg` holds:
  - the state enum (IDLE/RUN/DRAIN/DONE);
  - constants `CTL_FIRST`=0 and `CTL_LAST`=1;
  - the PE data widths (16-bit operands, 32-bit result).
- One natural sub-module, `serial_pe_agen`: the k/o/weight-address counters with a start-load and advance interface.
- FSM, ctl shadow stage and result counter stay in the top module.

## Test plan
- L=4, N=2, bases 0/0x100/0x200, no stall:
  - `w_addr` runs 0x100..0x107;
  - `n_addr` runs 0..3 twice;
  - `pe_ctl` per output = 01,00,00,10;
  - `r_wr` at cycles 6 and 10, to 0x200 and 0x201;
  - `done` at cycle 11.
- L=1, N=3: every `pe_vld_i` has `pe_ctl`=11; three consecutive `r_wr` in cycles 3–5; `done` at cycle 6.
- L=4, N=2 with `stall` high in cycles 3–4: `pe_vld_i` gap in cycles 4–5; all later events +2 cycles; `done` at cycle 13.
- `vec_len`=0: `done` pulse in cycle 1; no `n_rd`, `pe_vld_i` or `r_wr` at any time.
- `start` repeated while busy, and `w_base`=0x3FE with L=4: the second start is ignored; `w_addr` wraps 0x3FE, 0x3FF, 0x000, 0x001.
- `rst_n` low in cycle 4 of a long job: outputs return to reset values asynchronously; a new `start` after release begins cleanly from k=0, o=0.
